// File: rtl/fa_ha_registered.sv
// fa_ha_registered: registered ripple-carry adder, one full adder (two half adders + OR) per bit.
// Define FA_HA_OVF_EN to add the registered signed-overflow output ovf.
module fa_ha_registered #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g,
    output logic             out_valid
`ifdef FA_HA_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Handshake: valid-only, no ready. in_valid is the capture enable and is never stalled;
    // out_valid is high for exactly the cycle following an edge with rst=0 and in_valid=1.

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] p_d, g_d, s_d, t_d;
    logic             co_d;

    logic [WIDTH-1:0] s_q, p_q, g_q;
    logic             co_q;
    logic             out_valid_q;

    // Bit cell: HA1 forms propagate/generate, HA2 adds the incoming carry, OR merges carries.
    always_comb begin
        c   = '0;
        p_d = '0;
        g_d = '0;
        s_d = '0;
        t_d = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            p_d[i]   = a[i] ^ b[i];
            g_d[i]   = a[i] & b[i];
            s_d[i]   = p_d[i] ^ c[i];
            t_d[i]   = p_d[i] & c[i];
            c[i+1]   = g_d[i] | t_d[i];
        end
        co_d = c[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            p_q         <= '0;
            g_q         <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                s_q  <= s_d;
                p_q  <= p_d;
                g_q  <= g_d;
                co_q <= co_d;
            end
        end
    end

    assign s         = s_q;
    assign p         = p_q;
    assign g         = g_q;
    assign co        = co_q;
    assign out_valid = out_valid_q;

`ifdef FA_HA_OVF_EN
    logic ovf_d, ovf_q;

    // Carries into and out of the sign bit differ exactly on two's-complement overflow.
    assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fa_ha_registered.sv
// Bench for fa_ha_registered: three instances (WIDTH 1, 4, 8) share clock, reset and in_valid,
// and are checked every cycle against an arithmetic reference model plus directed constants.
module tb_fa_ha_registered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [7:0] a_in   [3];
    logic [7:0] b_in   [3];
    logic       cin_in [3];

    logic [0:0] s1, p1, g1;
    logic [3:0] s4, p4, g4;
    logic [7:0] s8, p8, g8;
    logic       co1, co4, co8;
    logic       ov1, ov4, ov8;

    fa_ha_registered #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a_in[0][0:0]), .b(b_in[0][0:0]), .cin(cin_in[0]),
        .s(s1), .co(co1), .p(p1), .g(g1),
`ifdef FA_HA_OVF_EN
        .ovf(ovf1),
`endif
        .out_valid(ov1)
    );

    fa_ha_registered #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a_in[1][3:0]), .b(b_in[1][3:0]), .cin(cin_in[1]),
        .s(s4), .co(co4), .p(p4), .g(g4),
`ifdef FA_HA_OVF_EN
        .ovf(ovf4),
`endif
        .out_valid(ov4)
    );

    fa_ha_registered #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a_in[2]), .b(b_in[2]), .cin(cin_in[2]),
        .s(s8), .co(co8), .p(p8), .g(g8),
`ifdef FA_HA_OVF_EN
        .ovf(ovf8),
`endif
        .out_valid(ov8)
    );

`ifdef FA_HA_OVF_EN
    logic ovf1, ovf4, ovf8;
    logic [7:0] obs_ovf [3];
    assign obs_ovf[0] = {7'd0, ovf1};
    assign obs_ovf[1] = {7'd0, ovf4};
    assign obs_ovf[2] = {7'd0, ovf8};
`endif

    logic [7:0] obs_s [3], obs_p [3], obs_g [3], obs_co [3], obs_ov [3];
    assign obs_s[0]  = {7'd0, s1};
    assign obs_s[1]  = {4'd0, s4};
    assign obs_s[2]  = s8;
    assign obs_p[0]  = {7'd0, p1};
    assign obs_p[1]  = {4'd0, p4};
    assign obs_p[2]  = p8;
    assign obs_g[0]  = {7'd0, g1};
    assign obs_g[1]  = {4'd0, g4};
    assign obs_g[2]  = g8;
    assign obs_co[0] = {7'd0, co1};
    assign obs_co[1] = {7'd0, co4};
    assign obs_co[2] = {7'd0, co8};
    assign obs_ov[0] = {7'd0, ov1};
    assign obs_ov[1] = {7'd0, ov4};
    assign obs_ov[2] = {7'd0, ov8};

    // Reference model state: what each instance's outputs should hold after the last edge.
    logic [7:0] exp_s [3], exp_p [3], exp_g [3], exp_co [3], exp_ov [3], exp_ovf [3];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int width_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    endfunction

    function automatic logic [7:0] mask_of(input int w);
        return 8'((1 << w) - 1);
    endfunction

    // Signed overflow: the true signed sum a+b+cin does not fit in w-bit two's complement.
    function automatic logic ref_ovf(input int w, input logic [7:0] a, input logic [7:0] b,
                                     input logic cin);
        int sa, sb, t;
        sa = int'(a & mask_of(w));
        sb = int'(b & mask_of(w));
        if (a[w-1]) sa = sa - (1 << w);
        if (b[w-1]) sb = sb - (1 << w);
        t = sa + sb + int'(cin);
        return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            int w;
            int unsigned sum;
            w = width_of(i);
            if (rst) begin
                exp_s[i] = 8'd0; exp_p[i] = 8'd0; exp_g[i] = 8'd0;
                exp_co[i] = 8'd0; exp_ov[i] = 8'd0; exp_ovf[i] = 8'd0;
            end else begin
                exp_ov[i] = {7'd0, in_valid};
                if (in_valid) begin
                    sum = int'(a_in[i] & mask_of(w)) + int'(b_in[i] & mask_of(w)) + int'(cin_in[i]);
                    exp_s[i]   = 8'(sum) & mask_of(w);
                    exp_co[i]  = {7'd0, sum[w]};
                    exp_p[i]   = (a_in[i] ^ b_in[i]) & mask_of(w);
                    exp_g[i]   = (a_in[i] & b_in[i]) & mask_of(w);
                    exp_ovf[i] = {7'd0, ref_ovf(w, a_in[i], b_in[i], cin_in[i])};
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            string t;
            t = $sformatf("%s.w%0d", tag, width_of(i));
            chk({t, ".s"},  obs_s[i],  exp_s[i]);
            chk({t, ".co"}, obs_co[i], exp_co[i]);
            chk({t, ".p"},  obs_p[i],  exp_p[i]);
            chk({t, ".g"},  obs_g[i],  exp_g[i]);
            chk({t, ".out_valid"}, obs_ov[i], exp_ov[i]);
`ifdef FA_HA_OVF_EN
            chk({t, ".ovf"}, obs_ovf[i], exp_ovf[i]);
`endif
        end
    endtask

    // One clock: inputs are already stable; model advances at the edge, outputs sampled 1ns later.
    task automatic clock_step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic cin);
        a_in[i] = a; b_in[i] = b; cin_in[i] = cin;
    endtask

    task automatic random_ops();
        for (int i = 0; i < 3; i++)
            set_ops(i, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    logic [7:0] cos_tbl [8] = '{8'h0, 8'h1, 8'h1, 8'h2, 8'h1, 8'h2, 8'h2, 8'h3};

    initial begin
        logic [2:0] kv;

        // Reset state
        rst = 1'b1; in_valid = 1'b0;
        random_ops();
        clock_step("reset0");
        in_valid = 1'b1;
        random_ops();
        clock_step("reset1");
        chk("reset.s8", obs_s[2], 8'h00);
        chk("reset.out_valid8", obs_ov[2], 8'h00);

        // Exhaustive single-bit full adder
        rst = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            kv = 3'(k);
            random_ops();
            set_ops(0, {7'd0, kv[2]}, {7'd0, kv[1]}, kv[0]);
            clock_step("exh");
            chk($sformatf("exh.cos.k%0d", k), {6'd0, obs_co[0][0], obs_s[0][0]}, cos_tbl[k]);
        end

        // Half-adder split visible on p/g
        set_ops(0, 8'd1, 8'd1, 1'b0);
        clock_step("pg1");
        chk("pg1.p", obs_p[0], 8'h0); chk("pg1.g", obs_g[0], 8'h1);
        chk("pg1.s", obs_s[0], 8'h0); chk("pg1.co", obs_co[0], 8'h1);
        set_ops(0, 8'd1, 8'd0, 1'b1);
        clock_step("pg2");
        chk("pg2.p", obs_p[0], 8'h1); chk("pg2.g", obs_g[0], 8'h0);
        chk("pg2.s", obs_s[0], 8'h0); chk("pg2.co", obs_co[0], 8'h1);

        // Carry rippling through all bits, then a signed overflow case
        set_ops(1, 8'hF, 8'h0, 1'b1);
        clock_step("w4_ripple");
        chk("w4_ripple.s", obs_s[1], 8'h0); chk("w4_ripple.co", obs_co[1], 8'h1);
        set_ops(1, 8'h5, 8'h3, 1'b0);
        clock_step("w4_ovf");
        chk("w4_ovf.s", obs_s[1], 8'h8); chk("w4_ovf.co", obs_co[1], 8'h0);
`ifdef FA_HA_OVF_EN
        chk("w4_ovf.ovf", obs_ovf[1], 8'h1);
`endif

        // Hold while in_valid is low
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            random_ops();
            clock_step("hold");
            chk("hold.s4", obs_s[1], 8'h8);
            chk("hold.out_valid4", obs_ov[1], 8'h0);
        end

        // Reset beats in_valid; operands in the reset cycle are dropped
        rst = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) set_ops(i, 8'hFF, 8'hFF, 1'b1);
        clock_step("rst_mid");
        chk("rst_mid.s4", obs_s[1], 8'h0); chk("rst_mid.co4", obs_co[1], 8'h0);
        chk("rst_mid.out_valid4", obs_ov[1], 8'h0);
        rst = 1'b0;
        set_ops(1, 8'h2, 8'h3, 1'b0);
        clock_step("after_rst");
        chk("after_rst.s4", obs_s[1], 8'h5); chk("after_rst.out_valid4", obs_ov[1], 8'h1);

        // Full wrap-around on every width
        for (int i = 0; i < 3; i++) set_ops(i, 8'hFF, 8'hFF, 1'b1);
        clock_step("wrap");
        chk("wrap.s8", obs_s[2], 8'hFF); chk("wrap.co8", obs_co[2], 8'h1);

        // Random traffic with random in_valid and occasional reset
        for (int n = 0; n < 1000; n++) begin
            random_ops();
            in_valid = 1'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            clock_step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
